// File: rtl/audio_dac_out_pkg.sv
// Shared constants and helpers for the audio DAC output path.
//   SAMPLE_W        : width of generator samples and the effective level
//   GAIN_MAX        : top of the soft-mute gain ramp (gain / 8 = unity)
//   PWM_STEPS       : PWM period length in clocks
//   DEFAULT_CLK_DIV : clocks per sample period (25 MHz / 16384 Hz)
package audio_dac_out_pkg;

  localparam int unsigned SAMPLE_W        = 4;
  localparam int unsigned GAIN_W          = 4;
  localparam int unsigned GAIN_MAX        = 8;
  localparam int unsigned PWM_STEPS       = 16;
  localparam int unsigned PWM_W           = $clog2(PWM_STEPS);
  localparam int unsigned PROD_W          = 7;
  localparam int unsigned DEFAULT_CLK_DIV = 1526;

  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } ramp_dir_e;

  // One ramp step, saturating at 0 and GAIN_MAX.
  function automatic logic [GAIN_W-1:0] gain_step(input logic [GAIN_W-1:0] gain,
                                                  input ramp_dir_e       dir);
    logic [GAIN_W-1:0] nxt;
    nxt = gain;
    if (dir == RAMP_DOWN) begin
      if (gain != '0) nxt = gain - GAIN_W'(1);
    end else begin
      if (gain < GAIN_W'(GAIN_MAX)) nxt = gain + GAIN_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/audio_dac_out_sd_mod1.sv
// First-order sigma-delta modulator.
//   clock, reset_n : system clock, async active-low reset
//   eff            : effective sample level (0..15)
//   sd_out         : 1-bit density-modulated output, ones density = eff/16
// The carry out of a 4-bit phase accumulator is the output bit; the carry is
// kept as bit 4 of the accumulator register so sd_out is a flop output.
module sd_mod1
  import audio_dac_out_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] eff,
  output logic                sd_out
);

  logic [SAMPLE_W:0] sd_acc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sd_acc <= '0;
    end else begin
      sd_acc <= {1'b0, sd_acc[SAMPLE_W-1:0]} + {1'b0, eff};
    end
  end

  assign sd_out = sd_acc[SAMPLE_W];

endmodule

// File: rtl/audio_dac_out.sv
// Audio DAC output stage: sample-rate divider, sample capture, volume
// attenuation, click-free mute ramp, PWM and sigma-delta outputs.
//   clock, reset_n : system clock, async active-low reset
//   sample_ena     : one-cycle request strobe to the sound generator
//   sample         : generator sample, valid the cycle after sample_ena
//   volume         : 3 = full scale .. 0 = 1/8
//   mute           : ramp gain down to silence while high
//   pwm_out        : 16-step PWM output
//   sd_out         : first-order sigma-delta output
//   level          : effective sample value for debug display
module audio_dac_out
  import audio_dac_out_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic                sample_ena,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [1:0]          volume,
  input  logic                mute,
  output logic                pwm_out,
  output logic                sd_out,
  output logic [SAMPLE_W-1:0] level
);

  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("audio_dac_out: CLK_DIV must be at least 4");
  end

  localparam int unsigned     DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]    div_cnt;
  logic                cap_stb;
  logic                eff_stb;
  logic [SAMPLE_W-1:0] held;
  logic [GAIN_W-1:0]   gain;
  logic [SAMPLE_W-1:0] scaled;
  logic [PROD_W-1:0]   prod;
  logic [SAMPLE_W-1:0] eff;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [SAMPLE_W-1:0] pwm_duty;
  ramp_dir_e           dir;

  // Sample-rate divider; the strobe is a decode of the counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign sample_ena = (div_cnt == DIV_LAST);

  assign dir = mute ? RAMP_DOWN : RAMP_UP;

  // The generator answers one cycle after the request, so capture and the
  // gain step happen on the delayed strobe; eff follows one cycle later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_stb <= 1'b0;
      eff_stb <= 1'b0;
      held    <= '0;
      gain    <= '0;
    end else begin
      cap_stb <= sample_ena;
      eff_stb <= cap_stb;
      if (cap_stb) begin
        held <= sample;
        gain <= gain_step(gain, dir);
      end
    end
  end

  always_comb begin
    scaled = held >> (2'd3 - volume);
    prod   = {3'b000, scaled} * {3'b000, gain};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eff <= '0;
    end else if (eff_stb) begin
      eff <= prod[PROD_W-1:PROD_W-SAMPLE_W];
    end
  end

  assign level = eff;

  // Duty only changes at the period boundary so every PWM period is whole.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt  <= '0;
      pwm_duty <= '0;
      pwm_out  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (pwm_cnt == '1) pwm_duty <= eff;
      pwm_out <= (pwm_cnt < pwm_duty);
    end
  end

  sd_mod1 u_sd_mod1 (
    .clock   (clock),
    .reset_n (reset_n),
    .eff     (eff),
    .sd_out  (sd_out)
  );

endmodule

// File: tb/tb_audio_dac_out.sv
module tb_audio_dac_out;

  localparam int unsigned DIV = 64;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] sample = '0;
  logic [1:0] volume = 2'd3;
  logic       mute = 1'b0;
  logic       sample_ena, pwm_out, sd_out;
  logic [3:0] level;
  logic       sample_ena8, pwm_out8, sd_out8;
  logic [3:0] level8;

  always #5 clock = ~clock;

  audio_dac_out #(.CLK_DIV(DIV)) dut (
    .clock(clock), .reset_n(reset_n), .sample_ena(sample_ena), .sample(sample),
    .volume(volume), .mute(mute), .pwm_out(pwm_out), .sd_out(sd_out), .level(level)
  );

  audio_dac_out #(.CLK_DIV(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .sample_ena(sample_ena8), .sample(sample),
    .volume(volume), .mute(mute), .pwm_out(pwm_out8), .sd_out(sd_out8), .level(level8)
  );

  typedef struct { int s; int v; int m; } stim_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    q_exp[$];
  int    gain_m = 0;
  stim_t plan[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: gain ramps one step per sample toward 8 (or 0 when
  // muted); level = ((sample >> (3-volume)) * gain) / 8.
  task automatic apply(input int s, input int v, input int m);
    sample = 4'(s);
    volume = 2'(v);
    mute   = (m != 0);
    if (m != 0) gain_m = (gain_m > 0) ? gain_m - 1 : 0;
    else        gain_m = (gain_m < 8) ? gain_m + 1 : 8;
    q_exp.push_back(((s >> (3 - v)) * gain_m) / 8);
  endtask

  task automatic wait_ena();
    bit got;
    got = 0;
    for (int i = 0; i < 2 * DIV && !got; i++) begin
      @(negedge clock);
      if (sample_ena) got = 1;
    end
    if (!got) check("sample_ena_timeout", 0, 1);
  endtask

  task automatic step(input int s, input int v, input int m);
    wait_ena();
    repeat (5) @(negedge clock);
    apply(s, v, m);
  endtask

  task automatic add(input int s, input int v, input int m, input int n);
    stim_t t;
    t.s = s; t.v = v; t.m = m;
    for (int i = 0; i < n; i++) plan.push_back(t);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sample_ena"}, sample_ena, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_pwm_out"}, pwm_out, 0);
    check({tag, "_sd_out"}, sd_out, 0);
  endtask

  // Monitor: sample-rate phase checks, level check 3 cycles after each
  // strobe, and PWM / sigma-delta ones counted over a 16-cycle window once
  // the new level has settled.
  initial begin
    int age, cyc, cyc8, pwm1, sd1, cur;
    bit done8;
    age = -1; cyc = 0; cyc8 = 0; pwm1 = 0; sd1 = 0; cur = -1; done8 = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        age = -1;
        cyc = 0;
        if (!done8) cyc8 = 0;
      end else begin
        if (sample_ena || (cyc % DIV == DIV - 1))
          check("ena_phase", sample_ena, int'(cyc % DIV == DIV - 1));
        cyc++;
        if (!done8) begin
          check("ena8_phase", sample_ena8, int'(cyc8 % 8 == 7));
          cyc8++;
          if (cyc8 == 40) done8 = 1;
        end
        if (sample_ena) age = 0;
        else if (age >= 0) age++;
        if (age == 3) begin
          if (q_exp.size() == 0) begin
            cur = -1;
            check("scoreboard_underflow", 1, 0);
          end else begin
            cur = q_exp.pop_front();
            check("level", level, cur);
          end
          pwm1 = 0;
          sd1 = 0;
        end
        if (age >= 30 && age <= 45) begin
          pwm1 += int'(pwm_out);
          sd1  += int'(sd_out);
        end
        if (age == 45) begin
          check("pwm_ones", pwm1, cur);
          check("sd_ones", sd1, cur);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    add(9, 3, 0, 10);   // ramp up, settle at level 9
    add(15, 1, 0, 1);   // scaled 3
    add(15, 0, 0, 1);   // scaled 1
    add(15, 3, 0, 1);   // full gain, level 15
    add(15, 3, 1, 3);   // 7, 6, 5
    add(15, 3, 0, 3);   // 6, 7, 8
    add(0, 3, 0, 2);    // silence
    add(15, 3, 1, 9);   // mute to zero
    add(15, 3, 0, 9);   // back to full, 15 of 16
    for (int i = 0; i < 40; i++)
      add($urandom_range(0, 15), $urandom_range(0, 3), int'($urandom_range(0, 3) == 0), 1);
    add(15, 3, 1, 9);
    add(15, 3, 0, 5);   // gain 5 when reset hits

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    apply(plan[0].s, plan[0].v, plan[0].m);
    @(posedge clock);
    #2 reset_n = 1'b1;
    for (int i = 1; i < plan.size(); i++) step(plan[i].s, plan[i].v, plan[i].m);

    wait_ena();
    repeat (10) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    q_exp.delete();
    gain_m = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("held_reset");
    apply(7, 3, 0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 9; i++) step(7, 3, 0);

    wait_ena();
    repeat (50) @(negedge clock);
    check("scoreboard_drained", q_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
